// File: rtl/game_pkg.sv
// Shared constants for the memorization game's button front end.
package game_pkg;

    // Button count and bit positions within every button vector.
    localparam int unsigned NUM_BTN    = 5;
    localparam int unsigned BTN_UP     = 0;
    localparam int unsigned BTN_DOWN   = 1;
    localparam int unsigned BTN_LEFT   = 2;
    localparam int unsigned BTN_RIGHT  = 3;
    localparam int unsigned BTN_CENTER = 4;

    // Consecutive differing samples required before a new level is accepted.
    localparam int unsigned STABLE_SAMPLES = 4;
    // Counter width; must hold STABLE_SAMPLES-1.
    localparam int unsigned CNT_W          = 3;

    typedef logic [NUM_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/debounce_cell.sv
// Debounce for one button: 2-FF synchronizer, qualification counter,
// registered level and single-cycle press/release pulses. Acts only on tick.
module debounce_cell #(
    parameter int unsigned STABLE_SAMPLES = 4,
    parameter int unsigned CNT_W          = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_SAMPLES - 1);

    logic             raw_meta_q, raw_sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_meta_q <= 1'b0;
            raw_sync_q <= 1'b0;
        end else begin
            raw_meta_q <= btn_raw;
            raw_sync_q <= raw_meta_q;
        end
    end

    // Qualify a level change over consecutive ticks; any agreeing sample restarts it.
    always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (tick) begin
            if (raw_sync_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntMax) begin
                cnt_d     = '0;
                level_d   = raw_sync_q;
                press_d   = raw_sync_q;
                release_d = ~raw_sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter, accepted level and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/button_debounce.sv
// Debounce and edge-detect the game's push-buttons. readClk is treated as a
// data signal: it is synchronized and its rising edge becomes a 1-clk tick.
module button_debounce
    import game_pkg::*;
#(
    parameter int unsigned NUM_BTN        = game_pkg::NUM_BTN,
    parameter int unsigned STABLE_SAMPLES = game_pkg::STABLE_SAMPLES,
    parameter int unsigned CNT_W          = game_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               readClk,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    logic rclk_meta_q, rclk_sync_q, rclk_prev_q;
    logic tick;

    // Synchronize readClk and keep its previous value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rclk_meta_q <= 1'b0;
            rclk_sync_q <= 1'b0;
            rclk_prev_q <= 1'b0;
        end else begin
            rclk_meta_q <= readClk;
            rclk_sync_q <= rclk_meta_q;
            rclk_prev_q <= rclk_sync_q;
        end
    end

    assign tick = rclk_sync_q & ~rclk_prev_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
        debounce_cell #(
            .STABLE_SAMPLES(STABLE_SAMPLES),
            .CNT_W         (CNT_W)
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (tick),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i])
        );
    end

endmodule
